dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and off-chip data memory. It serves hits with zero added latency. On a miss it sequences the dirty-line writeback and line refill over a request/ack memory handshake, and holds `cpu_stall_o` high until the access can complete. `cpu_stall_o` drives the `MemStall_i` freeze input of the pipeline registers.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_sram.sv | 68 ++++++
 rtl/dcache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, address-field constants and FSM state type for the data cache
package dcache_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int OFF_W          = 5;
  localparam int LINE_W         = 256;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int WSEL_W         = OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  function automatic int tag_width(input int idx_w);
    return ADDR_W - idx_w - OFF_W;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty/data line storage, async read, sync write with word enables
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = tag_width(IDX_W)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [IDX_W-1:0]          idx_i,
  output logic                      valid_o,
  output logic                      dirty_o,
  output logic [TAG_W-1:0]          tag_o,
  output logic [LINE_W-1:0]         line_o,
  input  logic                      line_we_i,
  input  logic [TAG_W-1:0]          tag_i,
  input  logic [WORDS_PER_LINE-1:0] word_en_i,
  input  logic [LINE_W-1:0]         wdata_i
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  // A line fill leaves the line clean; a partial word write marks it dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
    end else if (|word_en_i) begin
      dirty_d[idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i] <= tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (word_en_i[w]) begin
        data_q[idx_i][w*WORD_W +: WORD_W] <= wdata_i[w*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back/write-allocate data cache controller
// Optional DCACHE_STATS_EN adds access and miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       access_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = tag_width(IDX_W);
  localparam int LINE_WORDS = LINE_BYTES * 8 / WORD_W;

  state_e state_q, state_d;

  logic [TAG_W-1:0]      cpu_tag;
  logic [IDX_W-1:0]      cpu_idx;
  logic [WSEL_W-1:0]     cpu_wsel;
  logic                  unused_addr_bits;

  logic                  line_valid;
  logic                  line_dirty;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_W-1:0]     line_data;
  logic                  line_we;
  logic [LINE_WORDS-1:0] word_en;
  logic [LINE_W-1:0]     sram_wdata;

  logic                  hit;
  logic                  miss;

  assign cpu_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_wsel         = cpu_addr_i[2 +: WSEL_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit  = cpu_req_i & line_valid & (line_tag == cpu_tag);
  assign miss = cpu_req_i & ~hit;

  // The held request always points at the line under service, so one index port suffices.
  assign sram_wdata = line_we ? mem_data_i : {WORDS_PER_LINE{cpu_data_i}};

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx_i     (cpu_idx),
    .valid_o   (line_valid),
    .dirty_o   (line_dirty),
    .tag_o     (line_tag),
    .line_o    (line_data),
    .line_we_i (line_we),
    .tag_i     (cpu_tag),
    .word_en_i (word_en),
    .wdata_i   (sram_wdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (miss) state_d = line_dirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Everything is forced quiet while reset is held, whatever the state register still says.
  always_comb begin
    cpu_data_o  = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    line_we     = 1'b0;
    word_en     = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          cpu_stall_o = miss;
          if (hit && !cpu_we_i) cpu_data_o = line_data[cpu_wsel*WORD_W +: WORD_W];
          if (hit && cpu_we_i) word_en[cpu_wsel] = 1'b1;
        end
        WRITEBACK: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {line_tag, cpu_idx, {OFF_W{1'b0}}};
          mem_data_o  = line_data;
        end
        ALLOCATE: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_addr_o  = {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
          if (mem_ack_i) begin
            line_we = 1'b1;
            word_en = '1;
          end
        end
        default: cpu_stall_o = 1'b1;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] access_q, access_d;
  logic [31:0] miss_q, miss_d;

  always_comb begin
    access_d = access_q;
    miss_d   = miss_q;
    if (cpu_req_i && !cpu_stall_o) access_d = access_q + 32'd1;
    if (state_q == IDLE && state_d != IDLE) miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      access_q <= '0;
      miss_q   <= '0;
    end else begin
      access_q <= access_d;
      miss_q   <= miss_d;
    end
  end

  assign access_cnt_o = access_q;
  assign miss_cnt_o   = miss_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl against a flat-memory reference model
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  access_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .access_cnt_o (access_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [255:0] data;
    int           dly;
  } txn_t;

  txn_t        exp_mem_q[$];
  logic [31:0] exp_ld_q[$];
  bit          resp_en = 1'b1;

  // Architectural memory (what a load must see) and the off-chip memory contents.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bmem    [logic [31:0]];

  // Which line each index should hold, as seen from the access history.
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [22:0] m_tag   [16];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rd_bmem(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : dflt(a);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = rd_ref(base + 32'(4 * i));
    return l;
  endfunction

  // CPU-side monitor: every completing load is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_data", cpu_data_o, 0);
      end else if (cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
        if (exp_ld_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL load_unexpected: got load completion %0h, none expected", cpu_data_o);
        end else begin
          chk("load_data", cpu_data_o, exp_ld_q.pop_front());
        end
      end else begin
        chk("data_not_load_hit", cpu_data_o, 0);
      end
    end
  end

  // Memory responder and transaction monitor.
  initial begin
    txn_t         e;
    logic [31:0]  a;
    logic         w;
    logic [255:0] d;
    int           dly;
    forever begin
      @(negedge clk_i);
      if (resp_en && !rst_i && mem_req_o) begin
        a = mem_addr_o;
        w = mem_we_o;
        d = mem_data_o;
        dly = 0;
        if (exp_mem_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mem_unexpected: got addr %0h we %0d, no transaction expected", a, w);
        end else begin
          e = exp_mem_q.pop_front();
          chk("mem_addr", a, e.addr);
          chk("mem_we", w, e.we);
          if (e.we) chk("wb_line", d, e.data);
          dly = e.dly;
        end
        for (int k = 0; k < dly; k++) begin
          @(negedge clk_i);
          chk("hold_req", mem_req_o, 1);
          chk("hold_addr", mem_addr_o, a);
          chk("hold_we", mem_we_o, w);
          chk("hold_data", mem_data_o, d);
        end
        if (w) begin
          for (int i = 0; i < 8; i++) bmem[a + 32'(4 * i)] = d[i*32 +: 32];
        end else begin
          for (int i = 0; i < 8; i++) mem_data_i[i*32 +: 32] = rd_bmem(a + 32'(4 * i));
        end
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i  = 1'b0;
        mem_data_i = {8{$urandom()}};
      end
    end
  end

  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] data,
                           input int d_wb, input int d_al);
    logic [3:0]  idx;
    logic [22:0] tag;
    logic [31:0] waddr;
    logic [31:0] wb_base;
    int          exp_stall;
    int          st;
    bit          done;
    idx       = addr[8:5];
    tag       = addr[31:9];
    waddr     = {addr[31:2], 2'b00};
    exp_stall = 0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      exp_stall = 1;
      if (m_valid[idx] && m_dirty[idx]) begin
        wb_base = {m_tag[idx], idx, 5'b0};
        exp_mem_q.push_back('{wb_base, 1'b1, ref_line(wb_base), d_wb});
        exp_stall += d_wb + 1;
      end
      exp_mem_q.push_back('{{addr[31:5], 5'b0}, 1'b0, 256'b0, d_al});
      exp_stall += d_al + 1;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      ref_mem[waddr] = data;
      m_dirty[idx]   = 1'b1;
    end else begin
      exp_ld_q.push_back(rd_ref(waddr));
    end

    @(posedge clk_i);
    #1;
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = data;
    st   = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      if (!cpu_stall_o) begin
        done = 1'b1;
      end else begin
        st++;
        if (st > 300) begin
          n_vec++;
          n_err++;
          $display("FAIL stall_timeout: addr %0h still stalled after %0d cycles", addr, st);
          finish_run();
        end
      end
    end
    chk("stall_cycles", st, exp_stall);
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  initial begin
    bit          we;
    logic [31:0] addr;

    bmem[32'h400]    = 32'hDEADBEEF;
    ref_mem[32'h400] = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_stall", cpu_stall_o, 0);
    chk("reset_mem_req", mem_req_o, 0);

    do_access(1'b0, 32'h0000_0400, 32'h0, 0, 2);
    do_access(1'b1, 32'h0000_0404, 32'h1234_5678, 0, 0);
    do_access(1'b0, 32'h0000_0404, 32'h0, 0, 0);
    do_access(1'b0, 32'h0000_0600, 32'h0, 1, 5);
`ifdef DCACHE_STATS_EN
    @(negedge clk_i);
    chk("access_cnt", access_cnt_o, 4);
    chk("miss_cnt", miss_cnt_o, 2);
`endif

    // Reset in the middle of an unanswered refill.
    resp_en = 1'b0;
    @(posedge clk_i);
    #1;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0800;
    @(negedge clk_i);
    chk("abort_miss_stall", cpu_stall_o, 1);
    repeat (2) begin
      @(negedge clk_i);
      chk("abort_alloc_req", mem_req_o, 1);
      chk("abort_alloc_we", mem_we_o, 0);
      chk("abort_alloc_addr", mem_addr_o, 32'h0000_0800);
    end
    @(posedge clk_i);
    #1;
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset_mem_req", mem_req_o, 0);
    chk("post_reset_stall", cpu_stall_o, 0);
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    ref_mem = bmem;
    resp_en = 1'b1;
    do_access(1'b0, 32'h0000_0600, 32'h0, 0, 1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
        mem_ack_i  = 1'b1;
        mem_data_i = {8{$urandom()}};
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
      end
      we   = 1'($urandom_range(0, 1));
      addr = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
           | (32'($urandom_range(0, 7)) << 2);
      do_access(we, addr, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk_i);
    chk("mem_queue_drained", exp_mem_q.size(), 0);
    chk("load_queue_drained", exp_ld_q.size(), 0);
    finish_run();
  end

endmodule
